// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and address/count width helpers,
// common to the synchronous FIFO and the planned async FIFO.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Address width never drops below 1 so that a 1- or 2-entry array still has an index bit.
    function automatic int fifo_addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port and one read port that is
// either registered (with synchronous clear) or asynchronous.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = fifo_addr_width(DEPTH),
    parameter int REG_READ   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (REG_READ != 0) begin : g_reg_read
            logic [DATA_WIDTH-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= mem[rd_addr];
                end
            end

            assign rd_data = rd_q;
        end else begin : g_async_read
            // Combinational read has no use for the clear or the read strobe.
            logic unused_ok;
            assign unused_ok = ^{rst, rd_en};
            assign rd_data   = mem[rd_addr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through,
// almost-full/empty thresholds, occupancy count, flush and sticky error flags.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  wr_en,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    input  logic                                  rd_en,
    output logic [DATA_WIDTH-1:0]                 rd_data,
    output logic                                  full,
    output logic                                  empty,
    output logic                                  almost_full,
    output logic                                  almost_empty,
    output logic [fifo_cnt_width(FIFO_DEPTH)-1:0] count,
    output logic                                  overflow,
    output logic                                  underflow
);

    localparam int ADDR_WIDTH = fifo_addr_width(FIFO_DEPTH);
    localparam int CNT_WIDTH  = fifo_cnt_width(FIFO_DEPTH);

    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  AF_CNT    = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0]  AE_CNT    = CNT_WIDTH'(AE_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(FIFO_DEPTH - 1);

    if (FIFO_DEPTH < 2) begin : g_chk_depth
        $error("sync_fifo_flags: FIFO_DEPTH must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_chk_af
        $error("sync_fifo_flags: AF_LEVEL must lie in 1..FIFO_DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_chk_ae
        $error("sync_fifo_flags: AE_LEVEL must lie in 0..FIFO_DEPTH-1");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  active;
    logic                  rd_ok;
    logic                  wr_ok;

    // Flags decode only the registered count, so requests never reach them combinationally.
    assign count        = cnt_q;
    assign full         = (cnt_q == DEPTH_CNT);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= AF_CNT);
    assign almost_empty = (cnt_q <= AE_CNT);

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign active = ~rst & ~flush;
    assign rd_ok  = active & rd_en & ~empty;
    assign wr_ok  = active & wr_en & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (wr_en && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_READ   ((FWFT == FIFO_MODE_FWFT) ? 0 : 1)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: three instances (depth 8 standard, depth 5 standard,
// depth 8 FWFT) checked every cycle against a queue-based reference model.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;
    logic       flush   [3];
    logic       wr_en   [3];
    logic [7:0] wr_data [3];
    logic       rd_en   [3];
    logic [7:0] rd_data [3];
    logic       full    [3];
    logic       empty   [3];
    logic       af      [3];
    logic       ae      [3];
    logic       ovf     [3];
    logic       unf     [3];
    logic [3:0] count0;
    logic [2:0] count1;
    logic [3:0] count2;

    int tests = 0;
    int fails = 0;
    string phase = "init";

    logic [7:0] mq    [3][$];
    logic       m_ovf [3];
    logic       m_unf [3];
    logic [7:0] m_rd  [3];
    int         dep   [3] = '{8, 5, 8};
    int         afl   [3] = '{6, 4, 6};
    int         ael   [3] = '{1, 1, 1};
    bit         fw    [3] = '{1'b0, 1'b0, 1'b1};

    sync_fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)) u_s8 (
        .clk(clk), .rst(rst), .flush(flush[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
        .rd_en(rd_en[0]), .rd_data(rd_data[0]), .full(full[0]), .empty(empty[0]),
        .almost_full(af[0]), .almost_empty(ae[0]), .count(count0),
        .overflow(ovf[0]), .underflow(unf[0]));

    sync_fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_s5 (
        .clk(clk), .rst(rst), .flush(flush[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
        .rd_en(rd_en[1]), .rd_data(rd_data[1]), .full(full[1]), .empty(empty[1]),
        .almost_full(af[1]), .almost_empty(ae[1]), .count(count1),
        .overflow(ovf[1]), .underflow(unf[1]));

    sync_fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) u_ff (
        .clk(clk), .rst(rst), .flush(flush[2]), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
        .rd_en(rd_en[2]), .rd_data(rd_data[2]), .full(full[2]), .empty(empty[2]),
        .almost_full(af[2]), .almost_empty(ae[2]), .count(count2),
        .overflow(ovf[2]), .underflow(unf[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a queue of words; acceptance and flags follow directly from its size.
    task automatic model_step(input int i);
        int sz;
        bit rok;
        bit wok;
        logic [7:0] d;
        sz = mq[i].size();
        if (rst) begin
            mq[i].delete();
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
            if (!fw[i]) m_rd[i] = 8'h00;
        end else if (flush[i]) begin
            mq[i].delete();
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end else begin
            rok = rd_en[i] && (sz > 0);
            wok = wr_en[i] && ((sz < dep[i]) || rok);
            if (wr_en[i] && !wok) m_ovf[i] = 1'b1;
            if (rd_en[i] && !rok) m_unf[i] = 1'b1;
            if (rok) begin
                d = mq[i].pop_front();
                if (!fw[i]) m_rd[i] = d;
            end
            if (wok) mq[i].push_back(wr_data[i]);
        end
    endtask

    task automatic check_inst(input int i);
        int sz;
        logic [3:0] c;
        string p;
        sz = mq[i].size();
        p  = $sformatf("%s_u%0d", phase, i);
        case (i)
            0:       c = count0;
            1:       c = {1'b0, count1};
            default: c = count2;
        endcase
        chk({p, "_count"}, 32'(c), 32'(sz));
        chk({p, "_full"}, 32'(full[i]), 32'(sz == dep[i]));
        chk({p, "_empty"}, 32'(empty[i]), 32'(sz == 0));
        chk({p, "_af"}, 32'(af[i]), 32'(sz >= afl[i]));
        chk({p, "_ae"}, 32'(ae[i]), 32'(sz <= ael[i]));
        chk({p, "_ovf"}, 32'(ovf[i]), 32'(m_ovf[i]));
        chk({p, "_unf"}, 32'(unf[i]), 32'(m_unf[i]));
        if (!fw[i]) begin
            chk({p, "_rdata"}, 32'(rd_data[i]), 32'(m_rd[i]));
        end else if (sz > 0) begin
            chk({p, "_rdata"}, 32'(rd_data[i]), 32'(mq[i][0]));
        end
    endtask

    task automatic cycle();
        for (int i = 0; i < 3; i++) model_step(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_inst(i);
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            flush[i]   = 1'b0;
            wr_en[i]   = 1'b0;
            rd_en[i]   = 1'b0;
            wr_data[i] = 8'h00;
        end
    endtask

    initial begin
        int wp;
        for (int i = 0; i < 3; i++) begin
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
            m_rd[i]  = 8'h00;
        end
        idle();
        rst   = 1'b1;
        phase = "reset";
        cycle();
        chk("reset_empty", 32'(empty[0]), 32'd1);
        chk("reset_rdata", 32'(rd_data[0]), 32'd0);
        rst = 1'b0;
        cycle();

        // Fill and drain the depth-8 standard FIFO, including the rejected 9th write.
        phase = "fill";
        for (int k = 1; k <= 8; k++) begin
            wr_en[0] = 1'b1;
            wr_data[0] = 8'(k);
            cycle();
            if (k == 5) chk("t2_af_at5", 32'(af[0]), 32'd0);
            if (k == 6) chk("t2_af_at6", 32'(af[0]), 32'd1);
        end
        chk("t2_full", 32'(full[0]), 32'd1);
        wr_data[0] = 8'h09;
        cycle();
        chk("t2_ovf", 32'(ovf[0]), 32'd1);
        chk("t2_cnt_held", 32'(count0), 32'd8);
        wr_en[0] = 1'b0;
        rd_en[0] = 1'b1;
        phase = "drain";
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk("t2_rd_order", 32'(rd_data[0]), 32'(k));
        end
        rd_en[0] = 1'b0;

        // Flush at count 4 with overflow pending; the concurrent write must be dropped.
        phase = "flush";
        wr_en[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_data[0] = 8'h11 + 8'(k);
            cycle();
        end
        chk("t6_pre_cnt", 32'(count0), 32'd4);
        chk("t6_pre_ovf", 32'(ovf[0]), 32'd1);
        flush[0] = 1'b1;
        wr_data[0] = 8'hEE;
        cycle();
        chk("t6_cnt", 32'(count0), 32'd0);
        chk("t6_ovf", 32'(ovf[0]), 32'd0);
        chk("t6_rd_hold", 32'(rd_data[0]), 32'h08);
        idle();

        // Simultaneous read/write at full and at empty.
        phase = "simul";
        wr_en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wr_data[0] = 8'h21 + 8'(k);
            cycle();
        end
        rd_en[0] = 1'b1;
        wr_data[0] = 8'h29;
        cycle();
        chk("t4_full_cnt", 32'(count0), 32'd8);
        chk("t4_full_ovf", 32'(ovf[0]), 32'd0);
        chk("t4_full_rd", 32'(rd_data[0]), 32'h21);
        wr_en[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("t4_drain", 32'(rd_data[0]), 32'h22 + 32'(k));
        end
        wr_en[0] = 1'b1;
        wr_data[0] = 8'h30;
        cycle();
        chk("t4_empty_cnt", 32'(count0), 32'd1);
        chk("t4_empty_unf", 32'(unf[0]), 32'd1);
        idle();

        // Depth-5 wrap: pointers pass the 4->0 boundary several times.
        phase = "wrap";
        for (int rep = 0; rep < 4; rep++) begin
            wr_en[1] = 1'b1;
            for (int j = 0; j < 3; j++) begin
                wr_data[1] = 8'h40 + 8'(rep * 3 + j);
                cycle();
            end
            chk("t3_cnt3", 32'(count1), 32'd3);
            wr_en[1] = 1'b0;
            rd_en[1] = 1'b1;
            for (int j = 0; j < 3; j++) begin
                cycle();
                chk("t3_rd_order", 32'(rd_data[1]), 32'h40 + 32'(rep * 3 + j));
            end
            rd_en[1] = 1'b0;
        end

        // FWFT: head word visible without a read strobe.
        phase = "fwft";
        wr_en[2] = 1'b1;
        wr_data[2] = 8'hA5;
        cycle();
        chk("t5_head", 32'(rd_data[2]), 32'hA5);
        chk("t5_not_empty", 32'(empty[2]), 32'd0);
        idle();
        cycle();
        chk("t5_head_held", 32'(rd_data[2]), 32'hA5);
        rd_en[2] = 1'b1;
        cycle();
        chk("t5_popped", 32'(empty[2]), 32'd1);
        rd_en[2] = 1'b0;
        wr_en[2] = 1'b1;
        wr_data[2] = 8'h3C;
        cycle();
        chk("t5_next", 32'(rd_data[2]), 32'h3C);
        idle();

        // Random traffic on all instances with alternating fill/drain bias and a mid-run reset.
        phase = "rand";
        for (int n = 0; n < 800; n++) begin
            wp = ((n / 100) % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 3; i++) begin
                wr_en[i]   = ($urandom_range(0, 99) < wp);
                rd_en[i]   = ($urandom_range(0, 99) < (100 - wp));
                wr_data[i] = 8'($urandom);
                flush[i]   = ($urandom_range(0, 59) == 0);
            end
            rst = (n == 450 || n == 451);
            cycle();
            if (rst) begin
                chk("t1_rst_cnt", 32'(count0), 32'd0);
                chk("t1_rst_empty", 32'(empty[0]), 32'd1);
                chk("t1_rst_flags", 32'({full[0], af[0], ovf[0], unf[0]}), 32'd0);
                chk("t1_rst_rdata", 32'(rd_data[0]), 32'd0);
            end
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
